aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
Sequencer for the iterative AES-128 round datapath: one SubBytes/ShiftRows/MixColumns/AddRoundKey stage with an on-the-fly key-schedule stage, fed back through 128-bit state and key registers.
- Accepts one plaintext/key pair over a valid/ready handshake and latches both for the whole encryption.
- Drives the datapath's round index, first/last-round selects and register enable for NR rounds.
- Captures the ciphertext into an output register held under valid/ready backpressure.

Parameters:
NR, 10, number of rounds sequenced per block (AES-128 = 10)
RW, 4, width of round index; must satisfy 2**RW > NR
CW, 16, width of completed-block counter

Ports:
clk  input  1  clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
in_valid  input  1  plaintext/key pair offered
in_ready  output  1  controller can accept a pair this cycle
data_in  input  128  plaintext
key_in  input  128  cipher key
dp_data  output  128  latched plaintext to datapath
dp_key  output  128  latched key to datapath
dp_round  output  RW  current round index 0..NR-1 (also feeds rcon)
dp_first  output  1  1 when dp_round==0: datapath uses initial AddRoundKey result and dp_key
dp_last  output  1  1 when dp_round==NR-1: datapath bypasses MixColumns
dp_en  output  1  enable for datapath state and key registers
dp_result  input  128  combinational round output of datapath
out_valid  output  1  ciphertext available
out_ready  input  1  consumer takes ciphertext
data_out  output  128  registered ciphertext
busy  output  1  state != IDLE
blocks_done  output  CW  count of ciphertexts handed off

Behaviour:
- Single clock clk. Reset clr is synchronous and active-high, sampled on the rising edge; it has priority over every other event.
- Reset values: state=IDLE, round=0, out_valid=0, data_out=0, dp_data=0, dp_key=0, blocks_done=0.
- States:
  - IDLE: in_ready=1, dp_en=0.
  - RUN: in_ready=0, dp_en=1.
  - DONE: out_valid=1, dp_en=0, in_ready=out_ready.
- Accept = in_valid & in_ready.
  - On accept, latch data_in->dp_data and key_in->dp_key, set round=0, go to RUN.
  - dp_data and dp_key stay stable until the next accept.
- RUN, round < NR-1: round increments by 1 each cycle.
- RUN, round == NR-1: data_out <= dp_result, out_valid <= 1, round <= 0, go to DONE.
- dp_first and dp_last are combinational decodes of round, qualified by state==RUN. Both are 0 outside RUN.
- DONE, out_ready=1 (handoff):
  - Clear out_valid and increment blocks_done, which wraps modulo 2**CW.
  - If in_valid is also 1 in the same cycle, accept the new pair and go straight to RUN.
  - Otherwise go to IDLE.
- DONE, out_ready=0: hold data_out, out_valid and state unchanged.
- Latency: accept in cycle T, RUN cycles T+1..T+NR, out_valid high from T+NR+1. Back-to-back throughput is one block per NR+1 cycles.
- in_valid while not ready: ignored. No latching, and data_in/key_in may change freely.
- clr mid-RUN or mid-DONE: block aborted, ciphertext discarded, out_valid drops in the cycle after clr, no blocks_done increment.
- data_out changes only on RUN-exit capture or reset.

Decomposition:
- Shared package aes_pkg:
  - state encoding IDLE/RUN/DONE
  - AES128_NR=10
  - round-width constant
  - 128-bit block type
- One natural sub-module: round_counter. It has load-zero, enable and terminal-count output (round==NR-1) and is reused by a future decrypt controller.
- Handshake FSM and output register stay in aes_round_ctrl.

Test Plan:
- Reset, then key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly NR+1=11 cycles after accept, data_out=69c4e0d86a7b0430d8cdb78070b4c55a, blocks_done=1.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=0 for 5 cycles -> data_out=3925841d02dc09fbdc118597196a0b32 stable, in_ready=0; handoff on out_ready=1, then IDLE.
- Two pairs back-to-back, in_valid held, out_ready=1 -> second accept in the first pair's DONE cycle, both correct ciphertexts, outputs 11 cycles apart, blocks_done=2.
- Monitor during a block -> dp_round sequence 0..9, dp_first only at 0, dp_last only at 9, dp_en high exactly 10 cycles; data_in/key_in toggled during RUN has no effect.
- clr asserted at round 5 -> next cycle busy=0, out_valid=0, blocks_done unchanged; a fresh FIPS-197 block then produces the correct ciphertext.
- Force blocks_done to 16'hFFFF via repeated runs or preload, complete one block -> wraps to 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES round controller family.
package aes_pkg;

  // AES-128 round count and the index width that covers 0..AES128_NR-1.
  localparam int unsigned AES128_NR = 10;
  localparam int unsigned AES128_RW = 4;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/round_counter.sv
// Round index counter: clears on load_zero, advances while enabled and wraps
// to zero after the terminal round so the next block starts from round 0.
module round_counter
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES128_NR,
  parameter int unsigned RW = AES128_RW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_zero,
  input  logic          en,
  output logic [RW-1:0] round,
  output logic          term
);

  localparam logic [RW-1:0] LastRound = RW'(NR - 1);

  logic [RW-1:0] round_q, round_d;

  assign round = round_q;
  assign term  = (round_q == LastRound);

  // Next round index: load beats count; terminal round folds back to zero.
  always_comb begin
    round_d = round_q;
    if (load_zero) begin
      round_d = '0;
    end else if (en) begin
      round_d = term ? '0 : round_q + RW'(1);
    end
  end

  // Round index register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES-128 round datapath: accepts a plaintext/key
// pair, steps the datapath through NR rounds and holds the ciphertext under
// valid/ready backpressure.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES128_NR,
  parameter int unsigned RW = AES128_RW,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  data_in,
  input  logic [127:0]  key_in,
  output logic [127:0]  dp_data,
  output logic [127:0]  dp_key,
  output logic [RW-1:0] dp_round,
  output logic          dp_first,
  output logic          dp_last,
  output logic          dp_en,
  input  logic [127:0]  dp_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  data_out,
  output logic          busy,
  output logic [CW-1:0] blocks_done
);

  ctrl_state_e   state_q, state_d;
  block_t        dp_data_q, dp_key_q, data_out_q;
  logic          out_valid_q;
  logic [CW-1:0] blocks_done_q;

  logic          accept, handoff, run, round_term;
  logic [RW-1:0] round;

  assign run     = (state_q == StRun);
  assign accept  = in_valid & in_ready;
  assign handoff = (state_q == StDone) & out_ready;

  round_counter #(
    .NR (NR),
    .RW (RW)
  ) u_round_counter (
    .clk       (clk),
    .clr       (clr),
    .load_zero (accept),
    .en        (run),
    .round     (round),
    .term      (round_term)
  );

  // Handshake FSM: next state plus per-state ready and datapath enable.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    dp_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        dp_en = 1'b1;
        if (round_term) state_d = StDone;
      end
      StDone: begin
        // A new pair may enter in the same cycle the ciphertext leaves.
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand latches, ciphertext register and handoff counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StIdle;
      dp_data_q     <= '0;
      dp_key_q      <= '0;
      data_out_q    <= '0;
      out_valid_q   <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dp_data_q <= data_in;
        dp_key_q  <= key_in;
      end
      if (run && round_term) begin
        data_out_q  <= dp_result;
        out_valid_q <= 1'b1;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
      if (handoff) blocks_done_q <= blocks_done_q + CW'(1);
    end
  end

  assign dp_data     = dp_data_q;
  assign dp_key      = dp_key_q;
  assign dp_round    = round;
  assign dp_first    = run & (round == '0);
  assign dp_last     = run & round_term;
  assign out_valid   = out_valid_q;
  assign data_out    = data_out_q;
  assign busy        = (state_q != StIdle);
  assign blocks_done = blocks_done_q;

endmodule
